// File: rtl/decoder_seq.sv
// decoder_seq: registered binary-to-one-hot decoder with a valid/ready
// handshake on both the input and the output side.
// Build option: define DECODER_SEQ_SCAN_EN to compile in the walking-one
// sweep (IDLE/SCAN FSM, scan index, scan_start and busy). Without it,
// scan_start is ignored, busy is tied low and only the decode path exists.
// OUT must equal 2**IN.
module decoder_seq #(
  parameter int IN  = 3,
  parameter int OUT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           in_valid,
  input  logic [IN-1:0]  in_code,
  output logic           in_ready,
  output logic [OUT-1:0] y,
  output logic           y_valid,
  input  logic           y_ready,
  input  logic           scan_start,
  output logic           busy
);

  // Output word register and its "undelivered" flag.
  logic [OUT-1:0] y_q;
  logic           y_valid_q;

  // Decoded input code, loaded into y_q on an input transfer.
  logic [OUT-1:0] code_d;

  // The output register can take a new word this cycle.
  logic slot_free;
  // Handshake events; a disabled block neither accepts nor delivers.
  logic in_xfer;
  logic out_xfer;

  // One-hot decode of the incoming code, one comparator per output bit.
  generate
    for (genvar gi = 0; gi < OUT; gi++) begin : g_code_dec
      assign code_d[gi] = (in_code == IN'(gi));
    end
  endgenerate

  assign slot_free = !y_valid_q || y_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = en && y_valid_q && y_ready;

  assign y       = y_q;
  assign y_valid = y_valid_q;

`ifdef DECODER_SEQ_SCAN_EN

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Index of the last sweep word; its load ends the sweep.
  localparam logic [IN-1:0] LAST_IDX = IN'(OUT - 1);

  state_t         state_q;
  logic [IN-1:0]  idx_q;
  logic           busy_q;

  // Decoded scan index, loaded into y_q on each sweep step.
  logic [OUT-1:0] idx_d;

  // One-hot decode of the sweep index.
  generate
    for (genvar gi = 0; gi < OUT; gi++) begin : g_idx_dec
      assign idx_d[gi] = (idx_q == IN'(gi));
    end
  endgenerate

  // A scan request in the same cycle wins over an input word, so the
  // input is refused whenever scan_start is seen.
  assign in_ready = en && (state_q == IDLE) && !scan_start && slot_free;
  assign busy     = busy_q;

  // FSM plus output register: decode loads in IDLE, sweep loads in SCAN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          if (scan_start) begin
            state_q <= SCAN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            if (out_xfer) begin
              y_valid_q <= 1'b0;
            end
          end else if (in_xfer) begin
            y_q       <= code_d;
            y_valid_q <= 1'b1;
          end else if (out_xfer) begin
            y_valid_q <= 1'b0;
          end
        end
        SCAN: begin
          if (slot_free) begin
            y_q       <= idx_d;
            y_valid_q <= 1'b1;
            if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
              idx_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`else

  // Sweep logic absent: the block is always idle and scan_start has no use.
  logic unused_scan_start;
  assign unused_scan_start = scan_start;

  assign in_ready = en && slot_free;
  assign busy     = 1'b0;

  // Output register: load on input transfer, clear valid on delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else if (en) begin
      if (in_xfer) begin
        y_q       <= code_d;
        y_valid_q <= 1'b1;
      end else if (out_xfer) begin
        y_valid_q <= 1'b0;
      end
    end
  end

`endif

endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed bench for decoder_seq with a scoreboard queue.
// Expected words are pushed when an input is driven (or a sweep started)
// and popped by a monitor whenever the DUT delivers a word.
module tb_decoder_seq;

  localparam int IN  = 3;
  localparam int OUT = 8;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic           in_valid;
  logic [IN-1:0]  in_code;
  logic           in_ready;
  logic [OUT-1:0] y;
  logic           y_valid;
  logic           y_ready;
  logic           scan_start;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  logic [OUT-1:0] sb_q[$];
  logic [OUT-1:0] exp_w;

  decoder_seq #(.IN(IN), .OUT(OUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .in_ready   (in_ready),
    .y          (y),
    .y_valid    (y_valid),
    .y_ready    (y_ready),
    .scan_start (scan_start),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Delivery monitor: inputs are stable at the falling edge, so a transfer
  // seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && en && y_valid && y_ready) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_word observed=%0h expected=none", y);
      end
      if (sb_q.size() != 0) begin
        exp_w = sb_q.pop_front();
        checks++;
        assert (y === exp_w) else begin
          failures++;
          $error("FAIL delivered_word observed=%0h expected=%0h", y, exp_w);
        end
        $display("tb: delivered y=%0h", y);
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    in_valid   = 1'b0;
    in_code    = '0;
    y_ready    = 1'b0;
    scan_start = 1'b0;
    #1;
    chk("reset_y", 32'(y), 32'h0);
    chk("reset_y_valid", 32'(y_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_in_ready_en0", 32'(in_ready), 32'h0);
    tick();
    tick();

    // First transfer right after reset release: code 3 -> 0x08.
    rst_n    = 1'b1;
    en       = 1'b1;
    y_ready  = 1'b1;
    in_valid = 1'b1;
    in_code  = 3'd3;
    sb_q.push_back(8'h08);
    #1;
    chk("first_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("code3_y", 32'(y), 32'h08);
    chk("code3_y_valid", 32'(y_valid), 32'h1);
    tick();
    chk("drain_y_valid", 32'(y_valid), 32'h0);
    chk("drain_y_hold", 32'(y), 32'h08);

    // Back-to-back codes 0..7, one word per cycle.
    for (int c = 0; c < OUT; c++) begin
      in_valid = 1'b1;
      in_code  = IN'(c);
      sb_q.push_back(OUT'(1) << c);
      #1;
      chk("b2b_in_ready", 32'(in_ready), 32'h1);
      tick();
      chk("b2b_y", 32'(y), 32'(OUT'(1) << c));
      chk("b2b_y_valid", 32'(y_valid), 32'h1);
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_idle_y_valid", 32'(y_valid), 32'h0);

    // Back-pressure: code 6 held for 4 cycles while code 2 waits.
    y_ready  = 1'b0;
    in_valid = 1'b1;
    in_code  = 3'd6;
    sb_q.push_back(8'h40);
    tick();
    in_code = 3'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk("stall_y", 32'(y), 32'h40);
      chk("stall_y_valid", 32'(y_valid), 32'h1);
    end
    y_ready = 1'b1;
    sb_q.push_back(8'h04);
    #1;
    chk("unstall_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("unstall_y", 32'(y), 32'h04);
    tick();
    chk("unstall_drain", 32'(y_valid), 32'h0);

    // Enable low: word held, downstream cannot take it, nothing accepted.
    y_ready  = 1'b0;
    in_valid = 1'b1;
    in_code  = 3'd4;
    sb_q.push_back(8'h10);
    tick();
    en       = 1'b0;
    y_ready  = 1'b1;
    in_code  = 3'd1;
    #1;
    chk("en0_in_ready", 32'(in_ready), 32'h0);
    tick();
    tick();
    chk("en0_y", 32'(y), 32'h10);
    chk("en0_y_valid", 32'(y_valid), 32'h1);
    in_valid = 1'b0;
    en       = 1'b1;
    tick();
    chk("en1_y_valid", 32'(y_valid), 32'h0);
    chk("en1_y_hold", 32'(y), 32'h10);

`ifdef DECODER_SEQ_SCAN_EN
    // Sweep wins over a simultaneous input word.
    scan_start = 1'b1;
    in_valid   = 1'b1;
    in_code    = 3'd1;
    #1;
    chk("scan_in_ready", 32'(in_ready), 32'h0);
    tick();
    scan_start = 1'b0;
    in_code    = 3'd5;
    chk("scan_busy_start", 32'(busy), 32'h1);
    chk("scan_no_accept", 32'(y_valid), 32'h0);
    for (int k = 0; k < OUT; k++) sb_q.push_back(OUT'(1) << k);
    for (int k = 0; k < OUT; k++) begin
      tick();
      if (k == OUT - 1) in_valid = 1'b0;
      chk("scan_y", 32'(y), 32'(OUT'(1) << k));
      chk("scan_busy", 32'(busy), (k < OUT - 1) ? 32'h1 : 32'h0);
      if (k < OUT - 1) begin
        #1;
        chk("scan_ignore_in", 32'(in_ready), 32'h0);
      end
    end
    tick();
    chk("scan_end_y_valid", 32'(y_valid), 32'h0);
    chk("scan_end_busy", 32'(busy), 32'h0);

    // Reset in the middle of a sweep after three words.
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int k = 0; k < 3; k++) sb_q.push_back(OUT'(1) << k);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_pre_y", 32'(y), 32'(OUT'(1) << k));
    end
`else
    // Without the sweep, scan_start must not block a word or start anything.
    scan_start = 1'b1;
    in_valid   = 1'b1;
    in_code    = 3'd1;
    sb_q.push_back(8'h02);
    #1;
    chk("noscan_in_ready", 32'(in_ready), 32'h1);
    tick();
    scan_start = 1'b0;
    in_valid   = 1'b0;
    chk("noscan_y", 32'(y), 32'h02);
    chk("noscan_busy", 32'(busy), 32'h0);
    tick();
    chk("noscan_idle", 32'(y_valid), 32'h0);

    // Reset with an undelivered word pending.
    y_ready  = 1'b0;
    in_valid = 1'b1;
    in_code  = 3'd7;
    tick();
    in_valid = 1'b0;
    chk("prereset_y", 32'(y), 32'h80);
`endif

    // Asynchronous reset mid-cycle, then check that nothing more appears.
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_y", 32'(y), 32'h0);
    chk("async_rst_y_valid", 32'(y_valid), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    sb_q.delete();
    tick();
    rst_n   = 1'b1;
    y_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("post_rst_y_valid", 32'(y_valid), 32'h0);
      chk("post_rst_busy", 32'(busy), 32'h0);
    end

    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
